// File: rtl/button_conditioner.sv
// Per-channel button debouncer: 2-flop sync, shared sample tick, saturating qualify counter.
// debounced rises after PULSE_CNT_MAX consecutive high ticks, falls 3 clocks after in falls; edge_pulse is one cycle.
module button_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] PULSE_FULL  = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] r_sync_meta;
  logic [WIDTH-1:0] r_sync;
  logic [SW-1:0]    r_sample_cnt;
  logic [CW-1:0]    r_pulse_cnt [WIDTH];
  logic [WIDTH-1:0] r_debounced_q;
  logic             w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= in;
      r_sync      <= r_sync_meta;
    end
  end

  // With SAMPLE_CNT_MAX == 1 the counter is pinned at 0 and the tick is constant.
  assign w_tick = (r_sample_cnt == SAMPLE_LAST);

  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  // A synced low always wins, so any glitch shorter than the window restarts qualification.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst || !r_sync[i]) begin
        r_pulse_cnt[i] <= '0;
      end else if (w_tick && (r_pulse_cnt[i] < PULSE_FULL)) begin
        r_pulse_cnt[i] <= r_pulse_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    debounced = '0;
    for (int i = 0; i < WIDTH; i++) begin
      debounced[i] = (r_pulse_cnt[i] == PULSE_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_debounced_q <= '0;
    end else begin
      r_debounced_q <= debounced;
    end
  end

  assign edge_pulse = debounced & ~r_debounced_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Two DUT instances (4/3 and 1/1 sample/pulse settings) share stimulus; a tick-counting model checks both every cycle.
module tb_button_conditioner;

  localparam int MAXE = 65536;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_v = 4'b0000;
  logic [3:0] deb_a, pulse_a, deb_b, pulse_b;

  int n_vec = 0;
  int n_err = 0;

  button_conditioner #(.WIDTH(4), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)) u_dut_a (
    .clk(clk), .rst(rst), .in(in_v), .debounced(deb_a), .edge_pulse(pulse_a)
  );

  button_conditioner #(.WIDTH(4), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(1)) u_dut_b (
    .clk(clk), .rst(rst), .in(in_v), .debounced(deb_b), .edge_pulse(pulse_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: debounced is high once the current uninterrupted synced-high run
  // contains at least P sample ticks; ticks fall on edges e with (e - last_rst) % S == 0.
  logic [3:0] hist [MAXE];
  int         edge_n   = 0;
  int         last_rst = -1;
  int         run_start [2][4];
  logic [3:0] m_deb [2];
  logic [3:0] m_deb_prev [2];
  logic [3:0] m_pulse [2];
  int         m_s, m_p, m_ticks;
  logic       m_sync;

  always @(posedge clk) begin
    edge_n++;
    if (edge_n < MAXE) hist[edge_n] = in_v;
    if (rst) begin
      last_rst = edge_n;
      for (int k = 0; k < 2; k++) begin
        m_deb[k] = 4'b0000;
        for (int i = 0; i < 4; i++) run_start[k][i] = -1;
      end
    end else if (last_rst >= 0) begin
      for (int k = 0; k < 2; k++) begin
        m_s = (k == 0) ? 4 : 1;
        m_p = (k == 0) ? 3 : 1;
        for (int i = 0; i < 4; i++) begin
          m_sync = (edge_n - 2 > last_rst) ? hist[edge_n - 2][i] : 1'b0;
          if (!m_sync) begin
            run_start[k][i] = -1;
            m_deb[k][i]     = 1'b0;
          end else begin
            if (run_start[k][i] < 0) run_start[k][i] = edge_n;
            m_ticks = (edge_n - last_rst) / m_s - (run_start[k][i] - 1 - last_rst) / m_s;
            m_deb[k][i] = (m_ticks >= m_p);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      m_pulse[k]    = m_deb[k] & ~m_deb_prev[k];
      m_deb_prev[k] = m_deb[k];
    end
    if (last_rst >= 0) begin
      #2;
      check("model_deb_a",   deb_a,   m_deb[0]);
      check("model_pulse_a", pulse_a, m_pulse[0]);
      check("model_deb_b",   deb_b,   m_deb[1]);
      check("model_pulse_b", pulse_b, m_pulse[1]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  int rise, npulse, pulse_c, hits;
  int first_c [4];
  int cnt_p [4];
  int hold [4];

  initial begin
    for (int k = 0; k < 2; k++) m_deb_prev[k] = 4'b0000;
    rst  = 1'b1;
    in_v = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset_deb",   deb_a,   4'b0000);
    check("reset_pulse", pulse_a, 4'b0000);
    rst = 1'b0;

    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("idle_deb",   deb_a,   4'b0000);
      check("idle_pulse", pulse_a, 4'b0000);
    end

    // Fast instance: qualifies on the third clock after the rise.
    in_v[3] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_int("b_deb3",   int'(deb_b[3]),   int'(c >= 3));
      check_int("b_pulse3", int'(pulse_b[3]), int'(c == 3));
    end
    in_v[3] = 1'b0;
    repeat (5) @(negedge clk);

    // Long hold on channel 0.
    in_v[0] = 1'b1;
    rise = -1; npulse = 0; pulse_c = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (deb_a[0] && rise < 0) rise = c;
      if (pulse_a[0]) begin npulse++; pulse_c = c; end
    end
    check_int("a_rise_window",   int'(rise >= 11 && rise <= 15), 1);
    check_int("a_pulse_count",   npulse, 1);
    check_int("a_pulse_at_rise", pulse_c, rise);
    in_v[0] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_int("a_fall_deb0",    int'(deb_a[0]),   int'(c < 3));
      check_int("a_fall_nopulse", int'(pulse_a[0]), 0);
    end

    // Short glitches on channel 1 never qualify.
    hits = 0;
    repeat (5) begin
      in_v[1] = 1'b1;
      repeat (3) begin @(negedge clk); if (deb_a[1] || pulse_a[1]) hits++; end
      in_v[1] = 1'b0;
      repeat (3) begin @(negedge clk); if (deb_a[1] || pulse_a[1]) hits++; end
    end
    check_int("glitch_hits", hits, 0);

    // All channels together.
    in_v = 4'b1111;
    for (int i = 0; i < 4; i++) begin first_c[i] = -1; cnt_p[i] = 0; end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (pulse_a[i]) begin cnt_p[i]++; first_c[i] = c; end
    end
    check_int("all_pulse_seen", int'(first_c[0] > 0), 1);
    for (int i = 0; i < 4; i++) begin
      check_int("all_pulse_count", cnt_p[i], 1);
      check_int("all_pulse_same",  first_c[i], first_c[0]);
    end
    in_v = 4'b0000;
    repeat (6) @(negedge clk);

    // Reset during hold, then requalification.
    in_v[2] = 1'b1;
    for (int c = 0; c < 20 && !deb_a[2]; c++) @(negedge clk);
    check_int("rq_initial_qual", int'(deb_a[2]), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_int("rq_deb_after_rst",   int'(deb_a[2]),   0);
    check_int("rq_pulse_after_rst", int'(pulse_a[2]), 0);
    rise = -1; npulse = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (deb_a[2] && rise < 0) rise = c;
      if (pulse_a[2]) npulse++;
    end
    check_int("rq_rise_window", int'(rise >= 1 && rise <= 15), 1);
    check_int("rq_pulse_count", npulse, 1);
    in_v = 4'b0000;
    repeat (5) @(negedge clk);

    // Random levels with random hold lengths and occasional resets.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          in_v[i] = ~in_v[i];
          hold[i] = $urandom_range(1, 24);
        end else begin
          hold[i]--;
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    in_v = 4'b0000;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
